// File: rtl/mac_array_acc_pkg.sv
// Shared defaults and saturation bounds for the MAC array family.
package mac_array_acc_pkg;

  localparam int unsigned def_bw      = 4;
  localparam int unsigned def_psum_bw = 16;
  localparam int unsigned def_lanes   = 4;
  localparam int unsigned def_acc_len = 4;

  // Largest positive value of a w-bit signed number.
  function automatic logic signed [63:0] sat_max(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // Most negative value of a w-bit signed number.
  function automatic logic signed [63:0] sat_min(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/mac_tree.sv
// Stages P1 (per-lane multiply) and P2 (registered adder tree) of the MAC array.
module mac_tree
  import mac_array_acc_pkg::*;
#(
  parameter int unsigned bw      = def_bw,
  parameter int unsigned lanes   = def_lanes,
  parameter int unsigned psum_bw = def_psum_bw
) (
  input  logic                                  i_clk,
  input  logic                                  i_reset_n,
  input  logic                                  i_clear,
  input  logic                                  i_valid,
  input  logic                                  i_act_signed,
  input  logic                                  i_sat_en,
  input  logic [lanes*bw-1:0]                   i_x,
  input  logic [lanes*bw-1:0]                   i_w,
  input  logic [psum_bw-1:0]                    i_psum,
  output logic                                  o_valid,
  output logic                                  o_sat_en,
  output logic [psum_bw-1:0]                    o_psum,
  output logic signed [2*bw+$clog2(lanes)-1:0]  o_sum
);

  localparam int unsigned pw = 2 * bw;
  localparam int unsigned sw = pw + $clog2(lanes);

  logic signed [bw:0]    w_xe   [lanes];
  logic signed [bw-1:0]  w_we   [lanes];
  logic signed [pw-1:0]  w_prod [lanes];
  logic signed [pw-1:0]  r_prod [lanes];
  logic signed [sw-1:0]  w_sum;
  logic signed [sw-1:0]  r_sum;
  logic                  r_p1_valid;
  logic                  r_p2_valid;
  logic                  r_p1_sat_en;
  logic                  r_p2_sat_en;
  logic [psum_bw-1:0]    r_p1_psum;
  logic [psum_bw-1:0]    r_p2_psum;

  // Activations widen by one bit so unsigned values stay positive in a signed multiply.
  always_comb begin : lane_mult
    for (int i = 0; i < lanes; i++) begin
      w_xe[i]   = {i_act_signed & i_x[i*bw + bw - 1], i_x[i*bw +: bw]};
      w_we[i]   = i_w[i*bw +: bw];
      w_prod[i] = pw'(w_xe[i]) * pw'(w_we[i]);
    end
  end

  always_comb begin : adder_tree
    w_sum = '0;
    for (int i = 0; i < lanes; i++) begin
      w_sum = w_sum + sw'(r_prod[i]);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_p1_valid  <= 1'b0;
      r_p2_valid  <= 1'b0;
      r_p1_sat_en <= 1'b0;
      r_p2_sat_en <= 1'b0;
      r_p1_psum   <= '0;
      r_p2_psum   <= '0;
      r_sum       <= '0;
      for (int i = 0; i < lanes; i++) begin
        r_prod[i] <= '0;
      end
    end else begin
      r_p1_valid <= i_valid & ~i_clear;
      r_p2_valid <= r_p1_valid & ~i_clear;
      if (i_valid) begin
        r_p1_sat_en <= i_sat_en;
        r_p1_psum   <= i_psum;
        for (int i = 0; i < lanes; i++) begin
          r_prod[i] <= w_prod[i];
        end
      end
      if (r_p1_valid) begin
        r_p2_sat_en <= r_p1_sat_en;
        r_p2_psum   <= r_p1_psum;
        r_sum       <= w_sum;
      end
    end
  end

  assign o_valid  = r_p2_valid;
  assign o_sat_en = r_p2_sat_en;
  assign o_psum   = r_p2_psum;
  assign o_sum    = r_sum;

endmodule

// File: rtl/mac_array_acc.sv
// Multi-lane MAC with internal group accumulator: P3 accumulate, group counter and output register.
module mac_array_acc
  import mac_array_acc_pkg::*;
#(
  parameter int unsigned bw      = def_bw,
  parameter int unsigned psum_bw = def_psum_bw,
  parameter int unsigned lanes   = def_lanes,
  parameter int unsigned acc_len = def_acc_len
) (
  input  logic                           i_clk,
  input  logic                           i_reset_n,
  input  logic                           i_clear,
  input  logic                           i_act_signed,
  input  logic                           i_sat_en,
  input  logic                           i_valid_in,
  input  logic [lanes*bw-1:0]            i_x_in,
  input  logic [lanes*bw-1:0]            i_w_in,
  input  logic [psum_bw-1:0]             i_psum_in,
  output logic [psum_bw-1:0]             o_out,
  output logic                           o_out_valid,
  output logic [$clog2(acc_len+1)-1:0]   o_acc_cnt
);

  localparam int unsigned sw = 2 * bw + $clog2(lanes);
  localparam int unsigned cw = $clog2(acc_len + 1);
  localparam int unsigned aw = ((psum_bw > sw) ? psum_bw : sw) + 1;
  localparam logic signed [aw-1:0] sat_hi = aw'(sat_max(psum_bw));
  localparam logic signed [aw-1:0] sat_lo = aw'(sat_min(psum_bw));

  logic                        w_p2_valid;
  logic                        w_p2_sat_en;
  logic [psum_bw-1:0]          w_p2_psum;
  logic signed [sw-1:0]        w_p2_sum;

  logic signed [aw-1:0]        w_base;
  logic signed [aw-1:0]        w_full;
  logic signed [psum_bw-1:0]   w_reduced;

  logic signed [psum_bw-1:0]   r_acc;
  logic [cw-1:0]               r_cnt;
  logic [psum_bw-1:0]          r_out;
  logic                        r_out_valid;

  logic signed [psum_bw-1:0]   w_acc_nxt;
  logic [cw-1:0]               w_cnt_nxt;
  logic [psum_bw-1:0]          w_out_nxt;
  logic                        w_out_valid_nxt;

  mac_tree #(
    .bw      (bw),
    .lanes   (lanes),
    .psum_bw (psum_bw)
  ) u_tree (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_clear      (i_clear),
    .i_valid      (i_valid_in),
    .i_act_signed (i_act_signed),
    .i_sat_en     (i_sat_en),
    .i_x          (i_x_in),
    .i_w          (i_w_in),
    .i_psum       (i_psum_in),
    .o_valid      (w_p2_valid),
    .o_sat_en     (w_p2_sat_en),
    .o_psum       (w_p2_psum),
    .o_sum        (w_p2_sum)
  );

  // A zero count means the group is idle, so this vector seeds from its own psum.
  always_comb begin : acc_datapath
    w_base = (r_cnt == '0) ? aw'(signed'(w_p2_psum)) : aw'(r_acc);
    w_full = w_base + aw'(w_p2_sum);
    if (w_p2_sat_en && (w_full > sat_hi)) begin
      w_reduced = psum_bw'(sat_hi);
    end else if (w_p2_sat_en && (w_full < sat_lo)) begin
      w_reduced = psum_bw'(sat_lo);
    end else begin
      w_reduced = psum_bw'(w_full);
    end
  end

  always_comb begin : group_next
    w_acc_nxt       = r_acc;
    w_cnt_nxt       = r_cnt;
    w_out_nxt       = r_out;
    w_out_valid_nxt = 1'b0;
    if (i_clear) begin
      w_cnt_nxt = '0;
    end else if (w_p2_valid) begin
      w_acc_nxt = w_reduced;
      if (r_cnt == cw'(acc_len - 1)) begin
        w_cnt_nxt       = '0;
        w_out_nxt       = w_reduced;
        w_out_valid_nxt = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + cw'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_out       <= w_out_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  always_comb begin : out_drive
    o_out       = r_out;
    o_out_valid = r_out_valid;
    o_acc_cnt   = r_cnt;
  end

endmodule
